m_axi_burst: RTL and testbench

//  AXI4 burst master: the initiating end of the memory-mapped AXI4 links our slaves terminate.

---
 rtl/m_axi_burst.sv | 241 ++++++++++++++++++++++++
 tb/tb_m_axi_burst.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi_burst.sv
// AXI4 burst master: takes one local command at a time and runs a single
// INCR burst on the AXI4 write (AW/W/B) or read (AR/R) channels. Write data
// comes from a local valid/ready source; read data goes to a local sink.
module m_axi_burst #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DWIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  xrst,
    // local command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // local write source
    input  logic [DWIDTH-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // local read sink
    output logic [DWIDTH-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    // status
    output logic                  done,
    output logic                  err,
    // AXI write address
    output logic [ID_WIDTH-1:0]   awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    // AXI write data
    output logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI write response
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI read address
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    // AXI read data
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DWIDTH-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int         STRB_W   = DWIDTH / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RADDR = 3'd4,
        RDATA = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;

    logic in_wdata_s;
    logic in_rdata_s;
    logic last_s;
    logic w_fire_s;
    logic r_fire_s;
    logic unused_s;

    assign in_wdata_s = (state_q == WDATA);
    assign in_rdata_s = (state_q == RDATA);
    // The beat count, not rlast, defines the last beat of either burst.
    assign last_s     = (cnt_q == len_q);
    assign w_fire_s   = in_wdata_s && wr_valid && wready;
    assign r_fire_s   = in_rdata_s && rvalid && rd_ready;
    // Response IDs carry no information for a single-ID master.
    assign unused_s   = ^{bid, rid};

    // Next-state, burst bookkeeping and registered channel control.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = cmd_we ? WADDR : RADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            WADDR: begin
                if (awvalid_q && awready) begin
                    state_d = WDATA;
                end else begin
                    state_d = WADDR;
                end
            end
            WDATA: begin
                if (w_fire_s) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = last_s ? WRESP : WDATA;
                end else begin
                    state_d = WDATA;
                end
            end
            WRESP: begin
                if (bready_q && bvalid) begin
                    err_d   = (bresp != 2'b00);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WRESP;
                end
            end
            RADDR: begin
                if (arvalid_q && arready) begin
                    state_d = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end
            RDATA: begin
                if (r_fire_s) begin
                    cnt_d = cnt_q + 8'd1;
                    // Sticky within the burst: bad response or rlast out of step.
                    err_d = err_q || (rresp != 2'b00) || (rlast != last_s);
                    if (last_s) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are decoded from the next state so they are
        // registered yet line up exactly with the state they belong to.
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WADDR);
        arvalid_d   = (state_d == RADDR);
        bready_d    = (state_d == WRESP);
    end

    // State and control registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;

    assign awid      = {ID_WIDTH{1'b0}};
    assign awaddr    = addr_q;
    assign awlen     = len_q;
    assign awsize    = AXI_SIZE;
    assign awburst   = 2'b01;
    assign awvalid   = awvalid_q;

    assign arid      = {ID_WIDTH{1'b0}};
    assign araddr    = addr_q;
    assign arlen     = len_q;
    assign arsize    = AXI_SIZE;
    assign arburst   = 2'b01;
    assign arvalid   = arvalid_q;

    // Data channels pass straight through, gated by the owning state so
    // nothing moves before the address handshake or after the last beat.
    assign wvalid    = in_wdata_s && wr_valid;
    assign wr_ready  = in_wdata_s && wready;
    assign wdata     = wr_data;
    assign wstrb     = {STRB_W{1'b1}};
    assign wlast     = in_wdata_s && last_s;
    assign bready    = bready_q;

    assign rready    = in_rdata_s && rd_ready;
    assign rd_valid  = in_rdata_s && rvalid;
    assign rd_data   = rdata;
    assign rd_last   = in_rdata_s && last_s;

endmodule

// File: tb/tb_m_axi_burst.sv
// Bench for m_axi_burst: behavioural AXI slave, local write source and read
// sink, with scoreboard queues of expected beats and address fields.
module tb_m_axi_burst;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        xrst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        done, err;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready;
    logic        rlast, rvalid, rready;

    // knobs and scoreboard
    bit          slave_rand, src_rand, sink_rand;
    logic [1:0]  bresp_knob;
    int          bad_rlast_idx;
    cmd_t        cmd_q[$];
    beat_t       w_q[$];
    beat_t       r_q[$];
    logic [31:0] src_q[$];
    int          w_cnt, r_cnt;
    int          n_checks, n_pass;

    m_axi_burst #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .xrst(xrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // AXI slave model: observes handshakes at negedge, drives after posedge.
    initial begin : slave
        bit    aw_f, w_f, b_f, ar_f, r_f, aw_seen, b_pend, r_act;
        int    r_idx, r_len;
        logic [31:0] r_base;
        cmd_t  c;
        beat_t e;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rid = 1'b0;
        aw_seen = 1'b0; b_pend = 1'b0; r_act = 1'b0; r_idx = 0; r_len = 0; r_base = 32'd0;
        forever begin
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            if (xrst) begin
                if (aw_f || ar_f) begin
                    if (cmd_q.size() == 0) begin
                        check("addr_unexpected", 64'd1, 64'd0);
                    end else begin
                        c = cmd_q.pop_front();
                        if (aw_f) begin
                            check("awaddr", awaddr, c.addr);
                            check("awlen", awlen, c.len);
                            check("awsize", awsize, 3'd2);
                            check("awburst", awburst, 2'b01);
                            check("awid", awid, 1'b0);
                            aw_seen = 1'b1;
                        end else begin
                            check("araddr", araddr, c.addr);
                            check("arlen", arlen, c.len);
                            check("arsize", arsize, 3'd2);
                            check("arburst", arburst, 2'b01);
                            r_len = int'(c.len); r_base = c.addr; r_idx = 0; r_act = 1'b1;
                        end
                    end
                end
                if (w_f) begin
                    check("w_after_aw", aw_seen, 1'b1);
                    check("wstrb", wstrb, 4'hF);
                    if (w_q.size() == 0) begin
                        check("w_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = w_q.pop_front();
                        check("wdata", wdata, e.data);
                        check("wlast", wlast, e.last);
                    end
                    w_cnt++;
                    if (wlast) begin b_pend = 1'b1; aw_seen = 1'b0; end
                end
            end
            @(posedge clk); #1;
            if (!xrst) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
                aw_seen = 1'b0; b_pend = 1'b0; r_act = 1'b0;
                cmd_q.delete(); w_q.delete();
            end else begin
                awready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                wready  = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                arready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bvalid && b_f) bvalid = 1'b0;
                if (b_pend) begin bvalid = 1'b1; bresp = bresp_knob; b_pend = 1'b0; end
                if (rvalid && r_f) begin
                    rvalid = 1'b0;
                    r_idx++;
                    if (r_idx > r_len) r_act = 1'b0;
                end
                if (r_act && !rvalid && (!slave_rand || $urandom_range(0, 2) != 0)) begin
                    rdata  = 32'hC0DE_0000 + r_base + 32'(r_idx) * 32'd3;
                    rresp  = 2'b00;
                    rlast  = (r_idx == r_len) || (r_idx == bad_rlast_idx);
                    rvalid = 1'b1;
                    e.data = rdata;
                    e.last = (r_idx == r_len);
                    r_q.push_back(e);
                end
            end
        end
    end

    // Local write-data source fed from src_q.
    initial begin : source
        bit f;
        wr_valid = 1'b0; wr_data = 32'd0;
        forever begin
            @(negedge clk);
            f = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (!xrst) begin
                wr_valid = 1'b0; src_q.delete();
            end else begin
                if (f && src_q.size() > 0) void'(src_q.pop_front());
                wr_valid = (src_q.size() > 0) && (!src_rand || $urandom_range(0, 1) == 1);
                wr_data  = (src_q.size() > 0) ? src_q[0] : 32'd0;
            end
        end
    end

    // Local read sink: pops the scoreboard on every accepted beat.
    initial begin : sink
        bit    f;
        beat_t e;
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            f = rd_valid && rd_ready;
            if (xrst && f) begin
                if (r_q.size() == 0) begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    e = r_q.pop_front();
                    check("rd_data", rd_data, e.data);
                    check("rd_last", rd_last, e.last);
                end
                r_cnt++;
            end
            @(posedge clk); #1;
            if (!xrst) begin
                rd_ready = 1'b0; r_q.delete();
            end else begin
                rd_ready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_accept", ok, 1'b1);
        check("cmd_ready_drop", cmd_ready, 1'b0);
        check("err_clear_on_cmd", err, 1'b0);
    endtask

    task automatic wait_done(input logic exp_err, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check({tag, "_done"}, seen, 1'b1);
        check({tag, "_err"}, err, exp_err);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_err_hold"}, err, exp_err);
    endtask

    task automatic do_burst(input logic we, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] dbase, input logic exp_err, input string tag);
        cmd_t  c;
        beat_t b;
        int    c0;
        c.we = we; c.addr = addr; c.len = len;
        cmd_q.push_back(c);
        if (we) begin
            for (int i = 0; i <= int'(len); i++) begin
                b.data = dbase + 32'(i);
                b.last = (i == int'(len));
                w_q.push_back(b);
                src_q.push_back(b.data);
            end
        end
        c0 = we ? w_cnt : r_cnt;
        issue_cmd(we, addr, len);
        wait_done(exp_err, tag);
        check({tag, "_beats"}, (we ? w_cnt : r_cnt) - c0, int'(len) + 1);
        check({tag, "_sb_empty"}, w_q.size() + r_q.size() + cmd_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        int w0;
        n_checks = 0; n_pass = 0; w_cnt = 0; r_cnt = 0;
        slave_rand = 1'b0; src_rand = 1'b0; sink_rand = 1'b0;
        bresp_knob = 2'b00; bad_rlast_idx = -1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
        xrst = 1'b1;
        #2 xrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("rst_local", {wr_ready, rd_valid, done, err}, 4'b0);
        @(posedge clk); #1 xrst = 1'b1;

        // 1: write 4 beats, always-ready slave
        do_burst(1'b1, 32'h100, 8'd3, 32'd1, 1'b0, "t1_write");
        // 2: single-beat read
        do_burst(1'b0, 32'h40, 8'd0, 32'd0, 1'b0, "t2_read1");
        // 3: 8-beat read with stalls on both sides
        slave_rand = 1'b1; sink_rand = 1'b1; src_rand = 1'b1;
        do_burst(1'b0, 32'h80, 8'd7, 32'd0, 1'b0, "t3_read8");
        // 4: SLVERR write response, err held until next command
        bresp_knob = 2'b10;
        do_burst(1'b1, 32'h300, 8'd1, 32'h55, 1'b1, "t4_slverr");
        bresp_knob = 2'b00;
        repeat (5) @(negedge clk);
        check("t4_err_sticky", err, 1'b1);
        do_burst(1'b1, 32'h340, 8'd2, 32'hA0, 1'b0, "t4_next");
        // 5: early rlast, then a 256-beat read
        bad_rlast_idx = 1;
        do_burst(1'b0, 32'h500, 8'd3, 32'd0, 1'b1, "t5_rlast");
        bad_rlast_idx = -1;
        do_burst(1'b0, 32'h1000, 8'd255, 32'd0, 1'b0, "t5_len255");

        // 6: async reset during the second write beat
        slave_rand = 1'b0; sink_rand = 1'b0; src_rand = 1'b0;
        begin
            cmd_t  c;
            beat_t b;
            c.we = 1'b1; c.addr = 32'h200; c.len = 8'd3;
            cmd_q.push_back(c);
            for (int i = 0; i < 4; i++) begin
                b.data = 32'h77 + 32'(i); b.last = (i == 3);
                w_q.push_back(b); src_q.push_back(b.data);
            end
        end
        w0 = w_cnt;
        issue_cmd(1'b1, 32'h200, 8'd3);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (w_cnt >= w0 + 2) begin ok = 1'b1; break; end
        end
        check("t6_reach_beat2", ok, 1'b1);
        check("t6_pre_wvalid", wvalid, 1'b1);
        xrst = 1'b0;
        #1;
        check("t6_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("t6_rst_local", {wr_ready, rd_valid, done, err, cmd_ready}, 5'b0);
        repeat (3) @(posedge clk);
        #1 xrst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_cmd_ready", cmd_ready, 1'b1);
        do_burst(1'b1, 32'h600, 8'd3, 32'h10, 1'b0, "t6_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
